// File: rtl/ro_freq_compare.sv
// Ring-oscillator frequency comparator: counts rising edges of two synchronized RO outputs
// over a fixed window and reports which one is faster as a PUF response bit.
module ro_freq_compare #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WINDOW = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCount,
    StCompare,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] WinLast = CNT_W'(WINDOW - 1);

  state_e             state_q, state_d;
  // [0] meta, [1] synchronized, [2] history
  logic [2:0]         sync_a_q, sync_a_d;
  logic [2:0]         sync_b_q, sync_b_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]   count_a_q, count_a_d;
  logic [CNT_W-1:0]   count_b_q, count_b_d;
  logic               response_q, response_d;
  logic               tie_q, tie_d;
  logic               edge_a, edge_b;

  assign edge_a = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b = sync_b_q[1] & ~sync_b_q[2];

  always_comb begin
    sync_a_d   = {sync_a_q[1:0], ro_a};
    sync_b_d   = {sync_b_q[1:0], ro_b};
    state_d    = state_q;
    win_d      = win_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    response_d = response_q;
    tie_d      = tie_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        win_d   = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        state_d = StCount;
      end
      StCount: begin
        win_d = win_q + 1'b1;
        // Saturate rather than wrap so an overfast RO still compares as larger
        if (edge_a && (cnt_a_q != CntMax)) cnt_a_d = cnt_a_q + 1'b1;
        if (edge_b && (cnt_b_q != CntMax)) cnt_b_d = cnt_b_q + 1'b1;
        if (win_q == WinLast) state_d = StCompare;
      end
      StCompare: begin
        count_a_d  = cnt_a_q;
        count_b_d  = cnt_b_q;
        response_d = (cnt_a_q > cnt_b_q);
        tie_d      = (cnt_a_q == cnt_b_q);
        state_d    = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      win_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      count_a_q  <= '0;
      count_b_q  <= '0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      win_q      <= win_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
      response_q <= response_d;
      tie_q      <= tie_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign response = response_q;
  assign tie      = tie_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;

endmodule
